// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store stage: BRAM/MMIO access, sub-word formatting, BRAM read stall
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FC00,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              misalign,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_we,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  output logic [9:0]        io_addr,
  output logic              io_re,
  output logic              io_we,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RD_DONE = 2'd2} state_t;

  state_t            state, state_next;
  logic [1:0]        wait_cnt;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [31:0]       load_q;
  logic              is_mmio, access, bad_align, go, bram_rd, mmio_rd, wr, last_wait;

  function automatic logic [31:0] format_load(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b010:  format_load = word;
      3'b100:  format_load = {24'd0, b};
      3'b101:  format_load = {16'd0, h};
      default: format_load = 32'd0;
    endcase
  endfunction

  assign is_mmio = alu_result >= MMIO_BASE;
  // New requests are only taken in IDLE; RD_DONE deliberately ignores the still-held load.
  assign access  = !rst && (state == IDLE) && (mem_read || mem_write);

`ifdef MISALIGN_TRAP_EN
  assign bad_align = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                     ((funct3 == 3'b010) && (alu_result[1:0] != 2'b00));
`else
  assign bad_align = 1'b0;
`endif

  assign go        = access && !bad_align;
  assign bram_rd   = go && mem_read && !is_mmio;
  assign mmio_rd   = go && mem_read && is_mmio;
  assign wr        = go && mem_write && !mem_read;
  assign last_wait = wait_cnt == 2'(RD_LAT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
      addr_q   <= '0;
      funct3_q <= 3'd0;
      load_q   <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bram_rd) begin
            addr_q   <= alu_result[ADDR_W+1:0];
            funct3_q <= funct3;
            wait_cnt <= 2'd0;
          end
        end
        RD_WAIT: begin
          if (last_wait) begin
            load_q   <= format_load(dmem_rdata, addr_q[1:0], funct3_q);
            wait_cnt <= 2'd0;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bram_rd) state_next = RD_WAIT;
      RD_WAIT: if (last_wait) state_next = RD_DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall      = bram_rd || (!rst && (state == RD_WAIT));
    misalign   = access && bad_align;
    dmem_addr  = (state == IDLE) ? alu_result[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
    dmem_we    = 4'b0000;
    dmem_wdata = store_data;
    case (funct3)
      3'b000:  dmem_wdata = {4{store_data[7:0]}};
      3'b001:  dmem_wdata = {2{store_data[15:0]}};
      default: dmem_wdata = store_data;
    endcase
    if (wr && !is_mmio) begin
      case (funct3)
        3'b000:  dmem_we = 4'b0001 << alu_result[1:0];
        3'b001:  dmem_we = alu_result[1] ? 4'b1100 : 4'b0011;
        3'b010:  dmem_we = 4'b1111;
        default: dmem_we = 4'b0000;
      endcase
    end
    io_addr   = is_mmio ? alu_result[9:0] : 10'd0;
    io_re     = mmio_rd;
    io_we     = wr && is_mmio;
    io_wdata  = store_data;
    load_data = load_q;
    if (misalign) load_data = 32'd0;
    else if (mmio_rd) load_data = format_load(io_rdata, alu_result[1:0], funct3);
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed + randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;
  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned RD_LAT    = 1;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_FC00;

  logic              clk = 1'b0;
  logic              rst, mem_read, mem_write, stall, misalign, io_re, io_we, mem_init;
  logic [2:0]        funct3;
  logic [31:0]       alu_result, store_data, load_data, dmem_wdata, dmem_rdata, io_wdata, io_rdata;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_we;
  logic [9:0]        io_addr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] bram    [64];
  logic [31:0] rd_pipe [RD_LAT];
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W), .MMIO_BASE(MMIO_BASE), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .alu_result(alu_result), .store_data(store_data), .stall(stall), .load_data(load_data),
    .misalign(misalign), .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .io_addr(io_addr), .io_re(io_re), .io_we(io_we),
    .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  // Synchronous-read BRAM, aliased to 64 words
  assign dmem_rdata = rd_pipe[RD_LAT-1];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) bram[i] <= init_word(i);
    end else begin
      for (int i = 0; i < 4; i++)
        if (dmem_we[i]) bram[dmem_addr[5:0]][8*i +: 8] <= dmem_wdata[8*i +: 8];
    end
    rd_pipe[0] <= bram[dmem_addr[5:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] f);
    logic [31:0] b, h;
    b = (word >> (8 * (addr % 4))) & 32'hFF;
    h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd2:    return word;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fix_align(input logic [31:0] a, input logic [2:0] f);
`ifdef MISALIGN_TRAP_EN
    if (f == 3'd1 || f == 3'd5) return a & ~32'd1;
    if (f == 3'd2) return a & ~32'd3;
`endif
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    alu_result = 32'd0; store_data = 32'd0; io_rdata = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [2:0] f, input logic [31:0] addr, input logic [31:0] sd);
    logic [31:0] exp_we, exp_wd, mask;
    int          lane;
    exp_we = 32'd15; exp_wd = sd;
    if (f == 3'd0) begin
      lane = int'(addr % 4); exp_we = 32'd1 << lane; exp_wd = (sd & 32'hFF) * 32'h0101_0101;
      mask = 32'hFF << (8 * lane);
    end else if (f == 3'd1) begin
      lane = int'((addr / 2) % 2); exp_we = 32'd3 << (2 * lane); exp_wd = (sd & 32'hFFFF) * 32'h0001_0001;
      mask = 32'hFFFF << (16 * lane);
    end else begin
      mask = 32'hFFFF_FFFF;
    end
    mem_read = 1'b0; mem_write = 1'b1; funct3 = f; alu_result = addr; store_data = sd;
    @(negedge clk);
    chk("st_stall", 32'(stall), 32'd0);
    chk("st_misalign", 32'(misalign), 32'd0);
    chk("st_io_re", 32'(io_re), 32'd0);
    if (addr >= MMIO_BASE) begin
      chk("st_io_we", 32'(io_we), 32'd1);
      chk("st_io_addr", 32'(io_addr), addr & 32'h3FF);
      chk("st_io_wdata", io_wdata, sd);
      chk("st_mmio_dmem_we", 32'(dmem_we), 32'd0);
    end else begin
      chk("st_io_we", 32'(io_we), 32'd0);
      chk("st_dmem_we", 32'(dmem_we), exp_we);
      chk("st_dmem_wdata", dmem_wdata, exp_wd);
      chk("st_dmem_addr", 32'(dmem_addr), (addr >> 2) & 32'h3FFF);
      ref_mem[addr[7:2]] = (ref_mem[addr[7:2]] & ~mask) | (exp_wd & mask);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic do_load_bram(input logic [2:0] f, input logic [31:0] addr, input logic both);
    logic [31:0] exp;
    exp = ref_load(ref_mem[addr[7:2]], addr, f);
    mem_read = 1'b1; mem_write = both; funct3 = f; alu_result = addr; store_data = $urandom;
    @(negedge clk);
    chk("ld_req_stall", 32'(stall), 32'd1);
    chk("ld_req_addr", 32'(dmem_addr), (addr >> 2) & 32'h3FFF);
    chk("ld_req_we", 32'(dmem_we), 32'd0);
    chk("ld_req_io", 32'({io_re, io_we}), 32'd0);
    next_cycle();
    // The latched address/funct3 must be used, not whatever is on the inputs now
    alu_result = $urandom_range(0, 32'hFFFF_FBFF);
    funct3 = 3'($urandom_range(0, 7));
    for (int k = 0; k < RD_LAT; k++) begin
      @(negedge clk);
      chk("ld_wait_stall", 32'(stall), 32'd1);
      chk("ld_wait_addr", 32'(dmem_addr), (addr >> 2) & 32'h3FFF);
      next_cycle();
    end
    @(negedge clk);
    chk("ld_done_stall", 32'(stall), 32'd0);
    chk("ld_done_data", load_data, exp);
    chk("ld_done_we", 32'(dmem_we), 32'd0);
    chk("ld_done_misalign", 32'(misalign), 32'd0);
    next_cycle();
    idle_inputs();
  endtask

  task automatic do_load_mmio(input logic [2:0] f, input logic [31:0] addr, input logic [31:0] rdata);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = f; alu_result = addr; io_rdata = rdata;
    @(negedge clk);
    chk("io_ld_re", 32'(io_re), 32'd1);
    chk("io_ld_addr", 32'(io_addr), addr & 32'h3FF);
    chk("io_ld_data", load_data, ref_load(rdata, addr, f));
    chk("io_ld_stall", 32'(stall), 32'd0);
    chk("io_ld_we", 32'({io_we, dmem_we}), 32'd0);
    next_cycle();
    idle_inputs();
  endtask

  task automatic do_idle();
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'($urandom_range(0, 7));
    alu_result = $urandom; store_data = $urandom;
    @(negedge clk);
    chk("idle_strobes", 32'({stall, misalign, io_re, io_we, dmem_we}), 32'd0);
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    idle_inputs();
    rst = 1'b1; mem_init = 1'b1;
    mem_read = 1'b1; alu_result = 32'h40; funct3 = 3'd2;
    @(negedge clk);
    chk("rst_ld_stall", 32'({stall, io_re, misalign}), 32'd0);
    next_cycle();
    mem_init = 1'b0;
    mem_read = 1'b0; mem_write = 1'b1; alu_result = 32'hFFFF_FC08; store_data = 32'h1;
    @(negedge clk);
    chk("rst_st_strobes", 32'({io_we, dmem_we, stall}), 32'd0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("post_rst_load_data", load_data, 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    next_cycle();

    do_store(3'd2, 32'h10, 32'hDEAD_BEEF);
    do_store(3'd2, 32'h10, 32'h80FF_0000);
    do_load_bram(3'd0, 32'h13, 1'b0);
    chk("lb_example", load_data, 32'hFFFF_FF80);
    do_load_bram(3'd4, 32'h13, 1'b0);
    chk("lbu_example", load_data, 32'h0000_0080);
    do_store(3'd1, 32'h22, 32'h1234_ABCD);
    do_load_bram(3'd2, 32'h20, 1'b0);
    do_load_mmio(3'd2, 32'hFFFF_FC70, 32'h0000_005A);
    do_store(3'd2, 32'hFFFF_FBFC, 32'hCAFE_F00D);
    do_store(3'd2, 32'hFFFF_FC00, 32'h0BAD_CAFE);
    do_load_bram(3'd2, 32'h0004_0010, 1'b1);

    // Reset while a BRAM read is in flight
    mem_read = 1'b1; funct3 = 3'd2; alu_result = 32'h24;
    @(negedge clk);
    chk("abort_req_stall", 32'(stall), 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_strobes", 32'({stall, io_re, io_we, dmem_we, misalign}), 32'd0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_load_data", load_data, 32'd0);
    next_cycle();
    do_store(3'd0, 32'h31, 32'h0000_00A5);

`ifdef MISALIGN_TRAP_EN
    mem_read = 1'b1; funct3 = 3'd2; alu_result = 32'h11;
    @(negedge clk);
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_strobes", 32'({stall, io_re, io_we, dmem_we}), 32'd0);
    chk("mis_load_data", load_data, 32'd0);
    next_cycle();
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'd1; alu_result = 32'hFFFF_FC05;
    @(negedge clk);
    chk("mis_st_flag", 32'(misalign), 32'd1);
    chk("mis_st_strobes", 32'({io_we, dmem_we}), 32'd0);
    next_cycle();
    idle_inputs();
`else
    do_load_bram(3'd2, 32'h11, 1'b0);
    chk("lw_trunc", load_data, ref_mem[4]);
    do_load_bram(3'd1, 32'h13, 1'b0);
    chk("misalign_tied", 32'(misalign), 32'd0);
`endif

    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 5))
        0: begin
          f = 3'($urandom_range(0, 2));
          do_store(f, fix_align($urandom_range(0, 32'hFFFF_FBFF), f), $urandom);
        end
        1: begin
          f = 3'($urandom_range(0, 7));
          do_load_bram(f, fix_align($urandom_range(0, 32'hFFFF_FBFF), f), 1'b0);
        end
        2: begin
          f = 3'($urandom_range(0, 7));
          do_load_mmio(f, fix_align(MMIO_BASE + $urandom_range(0, 1023), f), $urandom);
        end
        3: begin
          f = 3'($urandom_range(0, 2));
          do_store(f, fix_align(MMIO_BASE + $urandom_range(0, 1023), f), $urandom);
        end
        4: do_idle();
        default: begin
          f = 3'($urandom_range(0, 7));
          a = fix_align($urandom_range(0, 255), f);
          do_load_bram(f, a, 1'b1);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
